// File: rtl/pruebas_pkg.sv
// Shared types, encodings and helpers for the shift-register stimulus sequencer.
package pruebas_pkg;

  localparam int unsigned ANCHO_CNT  = 8;
  localparam int unsigned ANCHO_LFSR = 8;
  localparam int unsigned ANCHO_D    = 4;
  localparam int unsigned ANCHO_TEST = 3;

  // Shift register operating modes
  typedef enum logic [1:0] {
    MODO_SERIE   = 2'b00,
    MODO_ROTA    = 2'b01,
    MODO_CARGA   = 2'b10,
    MODO_RETIENE = 2'b11
  } modo_t;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CARGA   = 2'd1,
    ST_EJECUTA = 2'd2,
    ST_FIN     = 2'd3
  } estado_t;

  // Test identifiers (0 means no test active)
  localparam logic [ANCHO_TEST-1:0] PRUEBA_NINGUNA = 3'd0;
  localparam logic [ANCHO_TEST-1:0] PRUEBA_1       = 3'd1;
  localparam logic [ANCHO_TEST-1:0] PRUEBA_2       = 3'd2;
  localparam logic [ANCHO_TEST-1:0] PRUEBA_3       = 3'd3;
  localparam logic [ANCHO_TEST-1:0] PRUEBA_4       = 3'd4;
  localparam logic [ANCHO_TEST-1:0] PRUEBA_5       = 3'd5;

  // Registered output bundle driven towards both register implementations
  typedef struct packed {
    logic               enb;
    logic               dir;
    modo_t              modo;
    logic               s_in;
    logic [ANCHO_D-1:0] d;
    logic               busy;
    logic               done;
  } salidas_t;

  // One LFSR step: taps at bits 0,2,3,4, shifting towards bit 0
  function automatic logic [ANCHO_LFSR-1:0] lfsr_sig(input logic [ANCHO_LFSR-1:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[4], l[ANCHO_LFSR-1:1]};
  endfunction

  // Outputs while idle or finishing: register held, nothing else driven
  function automatic salidas_t sal_reposo(input logic done);
    salidas_t s;
    s      = '0;
    s.modo = MODO_RETIENE;
    s.done = done;
    return s;
  endfunction

  // Outputs of a preload cycle: parallel load of the seed
  function automatic salidas_t sal_carga(input logic [ANCHO_D-1:0] semilla);
    salidas_t s;
    s      = '0;
    s.enb  = 1'b1;
    s.modo = MODO_CARGA;
    s.d    = semilla;
    s.busy = 1'b1;
    return s;
  endfunction

  // Outputs of one run cycle of the given test
  function automatic salidas_t sal_ejecuta(input logic [ANCHO_TEST-1:0] prueba,
                                           input logic [ANCHO_D-1:0]    cnt,
                                           input logic                  bit_lfsr);
    salidas_t s;
    s      = '0;
    s.enb  = 1'b1;
    s.busy = 1'b1;
    s.modo = MODO_RETIENE;
    case (prueba)
      PRUEBA_1: begin
        s.modo = MODO_CARGA;
        s.d    = cnt;
      end
      PRUEBA_2: begin
        s.modo = MODO_SERIE;
        s.s_in = bit_lfsr;
      end
      PRUEBA_3: begin
        s.modo = MODO_SERIE;
        s.dir  = 1'b1;
        s.s_in = bit_lfsr;
      end
      PRUEBA_4: begin
        s.modo = MODO_ROTA;
      end
      PRUEBA_5: begin
        s.modo = MODO_SERIE;
        s.dir  = 1'b1;
        s.s_in = bit_lfsr;
        s.enb  = ~cnt[0];
      end
      default: s.modo = MODO_RETIENE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/generador_pruebas_lfsr8.sv
// 8-bit LFSR providing pseudo-random serial data for the shift tests.
module lfsr8
  import pruebas_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOAD,
  input  logic [ANCHO_LFSR-1:0] SEED,
  input  logic                  ADV,
  output logic [ANCHO_LFSR-1:0] L
);

  // Reset and load both restore the seed; otherwise step only when asked
  always_ff @(posedge CLK) begin
    if (RESET) begin
      L <= SEED;
    end else if (LOAD) begin
      L <= SEED;
    end else if (ADV) begin
      L <= lfsr_sig(L);
    end
  end

endmodule

// File: rtl/generador_pruebas.sv
// Stimulus sequencer: runs five directed tests on the 4-bit shift register.
module generador_pruebas
  import pruebas_pkg::*;
#(
  parameter int unsigned          CICLOS_PRUEBA = 16,
  parameter logic [ANCHO_D-1:0]    SEMILLA_REG   = 4'b1001,
  parameter logic [ANCHO_LFSR-1:0] SEMILLA_LFSR  = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  HOLD,
  output logic                  ENB,
  output logic                  DIR,
  output logic [1:0]            MODO,
  output logic                  S_IN,
  output logic [ANCHO_D-1:0]    D,
  output logic [ANCHO_TEST-1:0] TEST_ID,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [ANCHO_CNT-1:0] ULTIMO = ANCHO_CNT'(CICLOS_PRUEBA - 1);

  estado_t               r_estado;
  logic [ANCHO_CNT-1:0]  r_cnt;
  logic [ANCHO_TEST-1:0] r_prueba;
  salidas_t              r_sal;

  logic                  w_prueba_lfsr;
  logic                  w_carga_lfsr;
  logic                  w_avanza_lfsr;
  logic [ANCHO_LFSR-1:0] w_l;
  logic [ANCHO_LFSR-1:0] w_l_sig;
  logic [ANCHO_CNT-1:0]  w_cnt_sig;

  // Tests that consume LFSR bits as serial data
  assign w_prueba_lfsr = (r_prueba == PRUEBA_2) || (r_prueba == PRUEBA_3) ||
                         (r_prueba == PRUEBA_5);
  assign w_carga_lfsr  = (r_estado == ST_IDLE) && START;
  assign w_avanza_lfsr = (r_estado == ST_EJECUTA) && w_prueba_lfsr && !HOLD;
  // LFSR value that will be current in the next cycle, so S_IN can be registered
  assign w_l_sig       = w_avanza_lfsr ? lfsr_sig(w_l) : w_l;
  assign w_cnt_sig     = r_cnt + ANCHO_CNT'(1);

  lfsr8 u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (w_carga_lfsr),
    .SEED  (SEMILLA_LFSR),
    .ADV   (w_avanza_lfsr),
    .L     (w_l)
  );

  // Sequencer FSM; outputs are registered for the step being entered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_estado <= ST_IDLE;
      r_cnt    <= '0;
      r_prueba <= PRUEBA_NINGUNA;
      r_sal    <= sal_reposo(1'b0);
    end else begin
      case (r_estado)
        ST_IDLE: begin
          r_sal <= sal_reposo(1'b0);
          if (START) begin
            r_estado <= ST_CARGA;
            r_cnt    <= '0;
            r_prueba <= PRUEBA_1;
            r_sal    <= sal_carga(SEMILLA_REG);
          end
        end
        ST_CARGA: begin
          if (HOLD) begin
            r_sal.enb <= 1'b0;
          end else begin
            r_estado <= ST_EJECUTA;
            r_cnt    <= '0;
            r_sal    <= sal_ejecuta(r_prueba, 4'd0, w_l_sig[0]);
          end
        end
        ST_EJECUTA: begin
          if (HOLD) begin
            r_sal.enb <= 1'b0;
          end else if (r_cnt == ULTIMO) begin
            r_cnt <= '0;
            if (r_prueba == PRUEBA_5) begin
              r_estado <= ST_FIN;
              r_prueba <= PRUEBA_NINGUNA;
              r_sal    <= sal_reposo(1'b1);
            end else begin
              r_estado <= ST_CARGA;
              r_prueba <= r_prueba + ANCHO_TEST'(1);
              r_sal    <= sal_carga(SEMILLA_REG);
            end
          end else begin
            r_cnt <= w_cnt_sig;
            r_sal <= sal_ejecuta(r_prueba, ANCHO_D'(w_cnt_sig), w_l_sig[0]);
          end
        end
        ST_FIN: begin
          r_estado <= ST_IDLE;
          r_sal    <= sal_reposo(1'b0);
        end
        default: begin
          r_estado <= ST_IDLE;
          r_prueba <= PRUEBA_NINGUNA;
          r_sal    <= sal_reposo(1'b0);
        end
      endcase
    end
  end

  assign ENB     = r_sal.enb;
  assign DIR     = r_sal.dir;
  assign MODO    = r_sal.modo;
  assign S_IN    = r_sal.s_in;
  assign D       = r_sal.d;
  assign BUSY    = r_sal.busy;
  assign DONE    = r_sal.done;
  assign TEST_ID = r_prueba;

endmodule

// File: tb/tb_generador_pruebas.sv
// Scoreboard bench for generador_pruebas: per-cycle reference model plus directed points.
module tb_generador_pruebas;

  localparam int N     = 16;
  localparam int TOTAL = 5 * (N + 1);
  localparam logic [3:0] SEM_REG  = 4'b1001;
  localparam logic [7:0] SEM_LFSR = 8'hA5;

  logic       CLK = 1'b0;
  logic       RESET, START, HOLD;
  logic       ENB, DIR, S_IN, BUSY, DONE;
  logic [1:0] MODO;
  logic [3:0] D;
  logic [2:0] TEST_ID;

  generador_pruebas #(
    .CICLOS_PRUEBA (N),
    .SEMILLA_REG   (SEM_REG),
    .SEMILLA_LFSR  (SEM_LFSR)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .HOLD    (HOLD),
    .ENB     (ENB),
    .DIR     (DIR),
    .MODO    (MODO),
    .S_IN    (S_IN),
    .D       (D),
    .TEST_ID (TEST_ID),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       enb;
    logic       dir;
    logic [1:0] modo;
    logic       s_in;
    logic [3:0] d;
    logic [2:0] tid;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // LFSR contents after n steps from the seed
  function automatic logic [7:0] lfsr_tras(input int n);
    logic [7:0] v;
    logic       fb;
    v = SEM_LFSR;
    for (int i = 0; i < n; i++) begin
      fb = v[0] ^ v[2] ^ v[3] ^ v[4];
      v  = {fb, v[7:1]};
    end
    return v;
  endfunction

  // Expected outputs for a position within the 5-test sequence
  function automatic obs_t esperado(input bit act, input bit fin, input int pos,
                                    input bit held, input int nadv);
    obs_t       o;
    int         t, w, j;
    logic [7:0] l;
    o      = '0;
    o.modo = 2'b11;
    if (fin) begin
      o.done = 1'b1;
    end else if (act) begin
      t      = pos / (N + 1) + 1;
      w      = pos % (N + 1);
      o.busy = 1'b1;
      o.tid  = 3'(t);
      o.enb  = 1'b1;
      if (w == 0) begin
        o.modo = 2'b10;
        o.d    = SEM_REG;
      end else begin
        j = w - 1;
        l = lfsr_tras(nadv);
        case (t)
          1: begin o.modo = 2'b10; o.d = 4'(j); end
          2: begin o.modo = 2'b00; o.s_in = l[0]; end
          3: begin o.modo = 2'b00; o.dir = 1'b1; o.s_in = l[0]; end
          4: begin o.modo = 2'b01; end
          default: begin
            o.modo = 2'b00; o.dir = 1'b1; o.s_in = l[0];
            o.enb  = ((j % 2) == 0);
          end
        endcase
      end
      if (held) o.enb = 1'b0;
    end
    return o;
  endfunction

  // Reference model: position in the sequence, hold flag and LFSR step count
  bit m_valido = 0, m_act = 0, m_fin = 0, m_hold = 0;
  int m_pos = 0, m_nadv = 0;

  always @(posedge CLK) begin
    int t, w;
    if (RESET) begin
      m_valido = 1; m_act = 0; m_fin = 0; m_hold = 0; m_pos = 0; m_nadv = 0;
    end else if (m_valido) begin
      if (m_fin) begin
        m_fin = 0;
      end else if (m_act) begin
        if (HOLD) begin
          m_hold = 1;
        end else begin
          m_hold = 0;
          t = m_pos / (N + 1) + 1;
          w = m_pos % (N + 1);
          if (w != 0 && (t == 2 || t == 3 || t == 5)) m_nadv++;
          m_pos++;
          if (m_pos == TOTAL) begin
            m_act = 0;
            m_fin = 1;
          end
        end
      end else if (START) begin
        m_act = 1; m_pos = 0; m_hold = 0; m_nadv = 0;
      end
    end
    if (m_valido) q.push_back(esperado(m_act, m_fin, m_pos, m_hold, m_nadv));
  end

  // Monitor: compare every presented cycle against the queued expectation
  always @(posedge CLK) begin
    obs_t act, exp;
    #1;
    if (q.size() > 0) begin
      exp = q.pop_front();
      act = '{enb: ENB, dir: DIR, modo: MODO, s_in: S_IN, d: D, tid: TEST_ID,
              busy: BUSY, done: DONE};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL salidas cyc=%0d: got enb,dir,modo,s_in,d,tid,busy,done=%b expected %b",
                 cyc, act, exp);
      end
    end
  end

  // One sequence from START with optional HOLD window and mid-run reset
  task automatic secuencia(input int max_m, input int hold_a, input int hold_b,
                           input int reset_at, output int busy_n, output int dones,
                           output int done_m);
    busy_n = 0; dones = 0; done_m = 0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int m = 1; m <= max_m; m++) begin
      if (BUSY) busy_n++;
      if (DONE) begin dones++; done_m = m; end
      if (reset_at == 0 || m <= reset_at) begin
        if (m == 1)  begin chk("tid_carga1", TEST_ID, 1); chk("d_carga1", D, 9); end
        if (m == 2)  begin chk("d_run0", D, 0); chk("modo_run0", MODO, 2); end
        if (m == 17) chk("d_run15", D, 15);
        if (m == 18) chk("tid_carga2", TEST_ID, 2);
        if (m == 19) begin
          chk("sin_p2_0", S_IN, 1); chk("modo_p2", MODO, 0);
          chk("dir_p2", DIR, 0);    chk("enb_p2", ENB, 1);
        end
        if (m == 20) chk("sin_p2_1", S_IN, 0);
        if (m == 40) chk("tid_p3", TEST_ID, 3);
      end
      if (reset_at == 0 && m == 69) chk("tid_carga5", TEST_ID, 5);
      if (hold_a != 0 && m == hold_a + 1) chk("enb_hold", ENB, 0);
      if (hold_a != 0 && m == hold_b + 2) chk("enb_tras_hold", ENB, 1);
      if (reset_at != 0 && m == reset_at + 1) begin
        chk("rst_enb", ENB, 0);   chk("rst_modo", MODO, 3); chk("rst_tid", TEST_ID, 0);
        chk("rst_busy", BUSY, 0); chk("rst_d", D, 0);       chk("rst_sin", S_IN, 0);
        chk("rst_dir", DIR, 0);   chk("rst_done", DONE, 0);
      end
      HOLD  = (m >= hold_a && m <= hold_b && hold_a != 0);
      RESET = (m == reset_at);
      START = (reset_at == 0) && (m == 10 || m == 86);
      @(negedge CLK);
    end
    START = 1'b0; HOLD = 1'b0; RESET = 1'b0;
  endtask

  initial begin
    int bn, dn, dm;
    RESET = 1'b1; START = 1'b0; HOLD = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (4) @(negedge CLK);

    // Plain run with ignored START pulses while busy and in FIN
    secuencia(92, 0, 0, 0, bn, dn, dm);
    chk("busy_ciclos", bn, 85);
    chk("done_pulsos", dn, 1);
    chk("done_ciclo", dm, 86);
    repeat (3) @(negedge CLK);

    // Three HOLD cycles inside test 5
    secuencia(95, 75, 77, 0, bn, dn, dm);
    chk("busy_ciclos_hold", bn, 88);
    chk("done_ciclo_hold", dm, 89);
    repeat (3) @(negedge CLK);

    // Reset in the middle of test 3, then a full replay
    secuencia(45, 0, 0, 40, bn, dn, dm);
    chk("done_tras_rst", dn, 0);
    repeat (2) @(negedge CLK);
    secuencia(90, 0, 0, 0, bn, dn, dm);
    chk("done_replay", dm, 86);

    // Random traffic checked by the model
    for (int i = 0; i < 700; i++) begin
      START = ($urandom_range(0, 19) == 0);
      HOLD  = ($urandom_range(0, 5) == 0);
      RESET = ($urandom_range(0, 299) == 0);
      @(negedge CLK);
    end
    START = 1'b0; HOLD = 1'b0; RESET = 1'b0;
    repeat (120) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/generador_pruebas.md
# generador_pruebas

Synchronous stimulus sequencer for the 4-bit shift register. On a START pulse it drives the register control and data inputs through five directed tests (prueba 1..5), tagging every cycle with the active test number, and then flags completion. Both register implementations (behavioural and structural) are driven in parallel from this block, so their Q and S_OUT streams can be compared test by test.

## Interface
- CICLOS_PRUEBA, 16, run cycles per test; legal range 2..255
- SEMILLA_REG, 4'b1001, value parallel-loaded in each test's preload cycle
- SEMILLA_LFSR, 8'hA5, LFSR value loaded on accepted START; must be nonzero
- CLK  input  1  single clock; all state changes on its rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  begin sequence; sampled only in IDLE
- HOLD  input  1  freeze sequencer while high
- ENB  output  1  register enable
- DIR  output  1  0 = left, 1 = right
- MODO  output  2  00 serial shift, 01 rotate, 10 parallel load, 11 hold
- S_IN  output  1  serial data in
- D  output  4  parallel data in
- TEST_ID  output  3  active test 1..5; 0 when idle
- BUSY  output  1  high from the first preload cycle through the last run cycle
- DONE  output  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, CARGA (one-cycle preload), EJECUTA (CICLOS_PRUEBA run cycles), FIN (one cycle).
- IDLE -> CARGA when START=1. Set TEST_ID=1, cnt=0, LFSR=SEMILLA_LFSR.
- CARGA -> EJECUTA after 1 cycle. Outputs: ENB=1, MODO=10, D=SEMILLA_REG, DIR=0, S_IN=0.
- EJECUTA: 8-bit cnt counts 0..CICLOS_PRUEBA-1. On the last count, TEST_ID<5 -> CARGA with TEST_ID+1; TEST_ID=5 -> FIN.
- FIN -> IDLE after 1 cycle. DONE=1 in FIN only.
- EJECUTA outputs per test (ENB=1 unless stated):
  - Prueba 1: MODO=10, D=cnt[3:0].
  - Prueba 2: MODO=00, DIR=0, S_IN=L[0].
  - Prueba 3: MODO=00, DIR=1, S_IN=L[0].
  - Prueba 4: MODO=01, DIR=0.
  - Prueba 5: MODO=00, DIR=1, S_IN=L[0], ENB=~cnt[0].
- Unused outputs are 0 in every state. In IDLE/FIN: ENB=0, MODO=11, TEST_ID=0.
- LFSR L[7:0]:
  - fb = L[0]^L[2]^L[3]^L[4]; next L = {fb, L[7:1]}.
  - Advances only in EJECUTA of tests 2, 3 and 5 when HOLD=0.
  - Not reloaded between tests.
- HOLD=1 in CARGA/EJECUTA:
  - state, cnt, TEST_ID and LFSR frozen;
  - ENB forced 0, other outputs unchanged;
  - BUSY stays 1.
- HOLD is ignored in IDLE/FIN.
- START while BUSY or in FIN is ignored. No queuing.

## Timing
- All outputs registered.
- START sampled high at edge k -> CARGA outputs visible after edge k, i.e. in cycle k+1.
- Sequence without HOLD = 5*(1+CICLOS_PRUEBA) cycles. DONE in the next cycle.
- Default (CICLOS_PRUEBA=16): BUSY high for 85 cycles, DONE in cycle k+86.
- Each HOLD cycle extends the sequence by exactly one cycle.
- RESET=1 at any edge, including mid-test:
  - state=IDLE, cnt=0, LFSR=SEMILLA_LFSR;
  - ENB=0, DIR=0, MODO=11, S_IN=0, D=0;
  - TEST_ID=0, BUSY=0, DONE=0.
- RESET has priority over START and HOLD.

## Structure
- Package pruebas_pkg:
  - MODO encodings (MODO_SERIE, MODO_ROTA, MODO_CARGA, MODO_RETIENE);
  - FSM state encoding;
  - TEST_ID constants 1..5.
- Sub-module lfsr8, with ports CLK, RESET, LOAD, SEED[7:0], ADV, L[7:0]. Implements the polynomial above.
- The top instance holds the FSM, cnt and the output registers.

## Test plan
- Reset mid-prueba 3 (cycle k+40): next cycle all outputs at reset values, state IDLE. A new START replays from TEST_ID=1.
- Default params, START at k: BUSY for cycles k+1..k+85, DONE only at k+86. TEST_ID=1 at k+1, 2 at k+18, 5 at k+69.
- Prueba 2, first two run cycles: S_IN=1, then 0 (LFSR A5 -> 52). MODO=00, DIR=0, ENB=1.
- Prueba 1 run cycles: D steps 0,1,...,15 with MODO=10. Preload cycle: D=1001.
- HOLD high for 3 cycles inside prueba 5: ENB=0, cnt and LFSR frozen. DONE slips to k+89.
- START pulses during BUSY and during FIN: no effect; DONE is still a single pulse.
